spmmio_arbiter: RTL and testbench

SPMMIO_ARBITER -- requirements
Module: spmmio_arbiter

---
 rtl/spmmio_arbiter_if.sv | 56 +++++
 rtl/spmmio_arbiter.sv | 122 ++++++++++++
 tb/tb_spmmio_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spmmio_arbiter_if.sv
// Bus bundle for the two-master MMIO arbiter: both Wishbone master ports,
// the shared slave-side request/response, and the one-hot grant.
interface spmmio_arbiter_if;
    logic [0:23] m0_adr_i;
    logic        m0_stb_i;
    logic        m0_cyc_i;
    logic        m0_we_i;
    logic [0:3]  m0_sel_i;
    logic [0:31] m0_dat_i;
    logic        m0_ack_o;
    logic        m0_err_o;
    logic [0:31] m0_dat_o;

    logic [0:23] m1_adr_i;
    logic        m1_stb_i;
    logic        m1_cyc_i;
    logic        m1_we_i;
    logic [0:3]  m1_sel_i;
    logic [0:31] m1_dat_i;
    logic        m1_ack_o;
    logic        m1_err_o;
    logic [0:31] m1_dat_o;

    logic [0:23] s_adr_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic        s_we_o;
    logic [0:3]  s_sel_o;
    logic [0:31] s_dat_o;
    logic        s_ack_i;
    logic [0:31] s_dat_i;

    logic [0:1]  grant_o;

    // Arbiter view
    modport slave (
        input  m0_adr_i, m0_stb_i, m0_cyc_i, m0_we_i, m0_sel_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_adr_i, m1_stb_i, m1_cyc_i, m1_we_i, m1_sel_i, m1_dat_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_adr_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output grant_o
    );

    // Environment view: the two masters plus the MMIO decoder
    modport master (
        output m0_adr_i, m0_stb_i, m0_cyc_i, m0_we_i, m0_sel_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_adr_i, m1_stb_i, m1_cyc_i, m1_we_i, m1_sel_i, m1_dat_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_adr_o, s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  grant_o
    );
endinterface

// File: rtl/spmmio_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the MMIO decoder.
// Optional stalled-strobe bus-error timeout: define SPMMIO_ARBITER_TIMEOUT_EN.
module spmmio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    spmmio_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last;

    logic w_g0;
    logic w_g1;
    logic w_leave;
    logic w_req_stb;
    logic w_mask;
    logic w_err;

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
            $error("spmmio_arbiter: TIMEOUT_CYCLES out of range 2..65535");
        end
    endgenerate

    // Arbitration FSM; r_last remembers the most recently granted master
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                        if (r_last) begin
                            r_state <= GNT0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= GNT1;
                            r_last  <= 1'b1;
                        end
                    end else if (bus.m0_cyc_i) begin
                        r_state <= GNT0;
                        r_last  <= 1'b0;
                    end else if (bus.m1_cyc_i) begin
                        r_state <= GNT1;
                        r_last  <= 1'b1;
                    end
                end
                GNT0: if (!bus.m0_cyc_i) r_state <= IDLE;
                GNT1: if (!bus.m1_cyc_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_g0    = (r_state == GNT0);
    assign w_g1    = (r_state == GNT1);
    assign w_leave = (w_g0 && !bus.m0_cyc_i) || (w_g1 && !bus.m1_cyc_i) || (r_state == IDLE);

    assign bus.grant_o[0] = w_g0;
    assign bus.grant_o[1] = w_g1;

    assign w_req_stb   = w_g0 ? bus.m0_stb_i : (w_g1 ? bus.m1_stb_i : 1'b0);
    assign bus.s_cyc_o = w_g0 ? bus.m0_cyc_i : (w_g1 ? bus.m1_cyc_i : 1'b0);
    assign bus.s_stb_o = w_req_stb & ~w_mask;
    assign bus.s_we_o  = w_g0 ? bus.m0_we_i  : (w_g1 ? bus.m1_we_i  : 1'b0);
    assign bus.s_adr_o = w_g0 ? bus.m0_adr_i : (w_g1 ? bus.m1_adr_i : 24'h0);
    assign bus.s_sel_o = w_g0 ? bus.m0_sel_i : (w_g1 ? bus.m1_sel_i : 4'h0);
    assign bus.s_dat_o = w_g0 ? bus.m0_dat_i : (w_g1 ? bus.m1_dat_i : 32'h0);

    assign bus.m0_ack_o = bus.s_ack_i & w_g0 & bus.m0_stb_i;
    assign bus.m1_ack_o = bus.s_ack_i & w_g1 & bus.m1_stb_i;
    assign bus.m0_dat_o = w_g0 ? bus.s_dat_i : 32'h0;
    assign bus.m1_dat_o = w_g1 ? bus.s_dat_i : 32'h0;

    // Errors only reach a master still holding cyc/stb, so abandoned accesses stay silent
    assign bus.m0_err_o = w_err & w_g0 & bus.m0_cyc_i & bus.m0_stb_i;
    assign bus.m1_err_o = w_err & w_g1 & bus.m1_cyc_i & bus.m1_stb_i;

`ifdef SPMMIO_ARBITER_TIMEOUT_EN
    localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_cnt;
    logic        r_err;
    logic        w_stall;

    assign w_stall = bus.s_stb_o & ~bus.s_ack_i;

    // r_err is the one-cycle error pulse; stb is masked during it so the counter restarts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 16'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_leave || !w_stall) begin
                r_cnt <= 16'd0;
            end else if (r_cnt == LP_LIMIT) begin
                r_cnt <= 16'd0;
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign w_mask = r_err;
    assign w_err  = r_err & ~bus.s_ack_i;
`else
    assign w_mask = 1'b0;
    assign w_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spmmio_arbiter.sv
// Directed bench for spmmio_arbiter: grant latency, round robin, bursts,
// async reset, and the timeout (or its absence, depending on the build).
module tb_spmmio_arbiter;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    spmmio_arbiter_if bus ();

    spmmio_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked 3ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        bus.m0_adr_i = '0; bus.m0_stb_i = 0; bus.m0_cyc_i = 0; bus.m0_we_i = 0;
        bus.m0_sel_i = '0; bus.m0_dat_i = '0;
        bus.m1_adr_i = '0; bus.m1_stb_i = 0; bus.m1_cyc_i = 0; bus.m1_we_i = 0;
        bus.m1_sel_i = '0; bus.m1_dat_i = '0;
        bus.s_ack_i  = 0;  bus.s_dat_i  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int bad_err;
    int bad_stb;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        clear_inputs();

        // Outputs held at zero during reset even with requests and ack present
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.s_ack_i = 1; bus.s_dat_i = 32'hdeadbeef;
        tick();
        tick();
        settle();
        chk("rst_grant", 32'(bus.grant_o), 32'd0);
        chk("rst_scyc", 32'(bus.s_cyc_o), 32'd0);
        chk("rst_ack0", 32'(bus.m0_ack_o), 32'd0);
        chk("rst_dat0", bus.m0_dat_o, 32'd0);
        clear_inputs();
        tick();
        reset = 1'b0;

        // Single read from master 0
        tick();
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 24'h000010; bus.m0_sel_i = 4'hF;
        settle();
        chk("rd_lat_idle", 32'(bus.s_cyc_o), 32'd0);
        tick();
        settle();
        chk("rd_scyc", 32'(bus.s_cyc_o), 32'd1);
        chk("rd_grant", 32'(bus.grant_o), 32'd2);
        chk("rd_sadr", 32'(bus.s_adr_o), 32'h10);
        chk("rd_noack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        settle();
        chk("rd_noack2", 32'(bus.m0_ack_o), 32'd0);
        tick();
        bus.s_ack_i = 1; bus.s_dat_i = 32'h12345678;
        settle();
        chk("rd_ack", 32'(bus.m0_ack_o), 32'd1);
        chk("rd_dat", bus.m0_dat_o, 32'h12345678);
        chk("rd_m1dat", bus.m1_dat_o, 32'd0);
        chk("rd_m1ack", 32'(bus.m1_ack_o), 32'd0);
        tick();
        clear_inputs();
        settle();
        chk("rd_rel_ack", 32'(bus.m0_ack_o), 32'd0);
        tick();
        settle();
        chk("rd_idle", 32'(bus.grant_o), 32'd0);

        // Tie after reset, then alternation with one idle cycle between grants
        do_reset();
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        settle();
        chk("rr_idle0", 32'(bus.grant_o), 32'd0);
        tick();
        settle();
        chk("rr_first", 32'(bus.grant_o), 32'd2);
        tick();
        bus.m0_cyc_i = 0;
        settle();
        chk("rr_hold", 32'(bus.grant_o), 32'd2);
        tick();
        settle();
        chk("rr_gap", 32'(bus.grant_o), 32'd0);
        tick();
        settle();
        chk("rr_second", 32'(bus.grant_o), 32'd1);
        tick();
        bus.m1_cyc_i = 0;
        tick();
        bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
        tick();
        settle();
        chk("rr_third", 32'(bus.grant_o), 32'd2);
        tick();
        clear_inputs();
        tick();

        // Master 1 burst of four strobes while master 0 waits
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 24'h0000A0;
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 24'h000B00;
        tick();
        settle();
        chk("bu_grant", 32'(bus.grant_o), 32'd1);
        chk("bu_sadr", 32'(bus.s_adr_o), 32'h000B00);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.s_ack_i = 1; bus.s_dat_i = 32'hA5A50000 + 32'(i);
            settle();
            chk("bu_m1ack", 32'(bus.m1_ack_o), 32'd1);
            chk("bu_m1dat", bus.m1_dat_o, 32'hA5A50000 + 32'(i));
            chk("bu_m0ack", 32'(bus.m0_ack_o), 32'd0);
            chk("bu_m0dat", bus.m0_dat_o, 32'd0);
            chk("bu_keep", 32'(bus.grant_o), 32'd1);
        end
        tick();
        bus.m1_cyc_i = 0; bus.m1_stb_i = 0; bus.s_ack_i = 0;
        settle();
        chk("bu_hold", 32'(bus.grant_o), 32'd1);
        tick();
        settle();
        chk("bu_gap", 32'(bus.grant_o), 32'd0);
        tick();
        settle();
        chk("bu_m0gnt", 32'(bus.grant_o), 32'd2);
        chk("bu_m0adr", 32'(bus.s_adr_o), 32'h0000A0);
        tick();
        clear_inputs();
        tick();

        // Asynchronous reset in the middle of a master 1 write
        bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_we_i = 1;
        bus.m1_dat_i = 32'hCAFEF00D; bus.m1_sel_i = 4'h3; bus.m1_adr_i = 24'h000040;
        tick();
        bus.s_ack_i = 1;
        settle();
        chk("wr_grant", 32'(bus.grant_o), 32'd1);
        chk("wr_swe", 32'(bus.s_we_o), 32'd1);
        chk("wr_sdat", bus.s_dat_o, 32'hCAFEF00D);
        chk("wr_ssel", 32'(bus.s_sel_o), 32'h3);
        chk("wr_ack", 32'(bus.m1_ack_o), 32'd1);
        reset = 1'b1;
        bus.m0_cyc_i = 1;
        #1;
        chk("ar_scyc", 32'(bus.s_cyc_o), 32'd0);
        chk("ar_grant", 32'(bus.grant_o), 32'd0);
        chk("ar_ack1", 32'(bus.m1_ack_o), 32'd0);
        chk("ar_swe", 32'(bus.s_we_o), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        bus.s_ack_i = 0;
        settle();
        chk("ar_idle", 32'(bus.grant_o), 32'd0);
        tick();
        settle();
        chk("ar_tie0", 32'(bus.grant_o), 32'd2);
        tick();
        clear_inputs();
        tick();

`ifdef SPMMIO_ARBITER_TIMEOUT_EN
        // Slave never acks: error pulse eight cycles after stb rises
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 24'h000080;
        tick();
        settle();
        chk("to_stb_rise", 32'(bus.s_stb_o), 32'd1);
        for (int j = 1; j <= 9; j++) begin
            tick();
            settle();
            if (j == 8) begin
                chk("to_err", 32'(bus.m0_err_o), 32'd1);
                chk("to_mask", 32'(bus.s_stb_o), 32'd0);
                chk("to_noack", 32'(bus.m0_ack_o), 32'd0);
                chk("to_m1err", 32'(bus.m1_err_o), 32'd0);
            end else begin
                chk("to_noerr", 32'(bus.m0_err_o), 32'd0);
                chk("to_stb", 32'(bus.s_stb_o), 32'd1);
            end
        end
        tick();
        clear_inputs();
        tick();
`else
        // Slave silent for 1000 cycles: no error, strobe never masked
        bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 24'h000080;
        tick();
        bad_err = 0;
        bad_stb = 0;
        for (int j = 0; j < 1000; j++) begin
            settle();
            if (bus.m0_err_o !== 1'b0 || bus.m1_err_o !== 1'b0) bad_err++;
            if (bus.s_stb_o !== 1'b1) bad_stb++;
            tick();
        end
        settle();
        chk("ne_err_cycles", 32'(bad_err), 32'd0);
        chk("ne_stb_cycles", 32'(bad_stb), 32'd0);
        chk("ne_stb_end", 32'(bus.s_stb_o), 32'd1);
        chk("ne_err_end", 32'(bus.m0_err_o), 32'd0);
        tick();
        clear_inputs();
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
